// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide by zero finishes immediately with an all-ones quotient and the dividend as remainder.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] v_reg, v_next;
  logic [WIDTH:0]   p_reg, p_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] d_shift;
  logic [WIDTH:0]   p_step;

  // One restoring step: the trial subtraction's sign bit decides keep-or-restore.
  always_comb begin
    shifted_rem = {p_reg[WIDTH-1:0], d_reg[WIDTH-1]};
    trial       = shifted_rem - {1'b0, v_reg};
    q_bit       = ~trial[WIDTH];
    d_shift     = {d_reg[WIDTH-2:0], q_bit};
    p_step      = q_bit ? trial : shifted_rem;
  end

  always_comb begin
    state_next     = state_reg;
    d_next         = d_reg;
    v_next         = v_reg;
    p_next         = p_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          d_next   = Dividend;
          v_next   = Divisor;
          p_next   = '0;
          cnt_next = '0;
          if (Divisor == '0) begin
            state_next     = DONE;
            quotient_next  = '1;
            remainder_next = Dividend;
            dbz_next       = 1'b1;
          end else begin
            state_next = RUN;
            dbz_next   = 1'b0;
          end
        end
      end
      RUN: begin
        d_next   = d_shift;
        p_next   = p_step;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) begin
          quotient_next  = d_shift;
          remainder_next = p_step[WIDTH-1:0];
          state_next     = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      d_reg         <= '0;
      v_reg         <= '0;
      p_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      d_reg         <= d_next;
      v_reg         <= v_next;
      p_reg         <= p_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign Quotient    = quotient_reg;
  assign Remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
